core_dmem_arbiter: RTL and testbench

//  Shares the single core data memory port between two requesters:
//  p0 (core LSU, execute stage) and p1 (debug/DMA access port).

---
 rtl/core_dmem_arbiter_pkg.sv | 14 +
 rtl/core_dmem_arb_sel.sv | 85 ++++++++
 rtl/core_dmem_arbiter.sv | 114 +++++++++++
 tb/tb_core_dmem_arbiter.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/core_dmem_arbiter_pkg.sv
// core_dmem_arbiter_pkg
//   Shared widths and port identifiers for the core data-memory arbiter.
//   MEM_ADDR_R / MEM_DATA_R / MEM_STRB_R : default bus widths
//   ARB_P0 / ARB_P1                      : select encoding (p0 = LSU, p1 = debug/DMA)
package core_dmem_arbiter_pkg;

  localparam int MEM_ADDR_R = 64;
  localparam int MEM_DATA_R = 64;
  localparam int MEM_STRB_R = MEM_DATA_R / 8;

  localparam logic ARB_P0 = 1'b0;
  localparam logic ARB_P1 = 1'b1;

endpackage

// File: rtl/core_dmem_arb_sel.sv
// core_dmem_arb_sel
//   Requester select for the dmem arbiter: owns the lock and priority
//   registers and produces sel. No datapath here.
//   Build option: CORE_DMEM_ARB_RR_EN -> round-robin priority; otherwise
//   p0 always wins a contest and no priority flop exists.
//
//   clk_i      in   clock
//   rst_ni     in   async reset, active low
//   req0_i     in   p0 request
//   req1_i     in   p1 request
//   bus_req_i  in   request actually presented to memory this cycle
//   bus_gnt_i  in   memory grant
//   sel_o      out  selected requester (ARB_P0 / ARB_P1)
module core_dmem_arb_sel
  import core_dmem_arbiter_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic req0_i,
  input  logic req1_i,
  input  logic bus_req_i,
  input  logic bus_gnt_i,
  output logic sel_o
);

  logic lock_valid_q, lock_valid_d;
  logic lock_owner_q, lock_owner_d;
  logic prio;

  always_comb begin
    if (lock_valid_q) begin
      sel_o = lock_owner_q;
    end else if (req0_i ^ req1_i) begin
      sel_o = req1_i ? ARB_P1 : ARB_P0;
    end else begin
      sel_o = prio;
    end
  end

  // A stalled request pins the bus to its owner until memory accepts it.
  always_comb begin
    lock_valid_d = lock_valid_q;
    lock_owner_d = lock_owner_q;
    if (bus_gnt_i) begin
      lock_valid_d = 1'b0;
    end else if (bus_req_i) begin
      lock_valid_d = 1'b1;
      lock_owner_d = sel_o;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_valid_q <= 1'b0;
      lock_owner_q <= ARB_P0;
    end else begin
      lock_valid_q <= lock_valid_d;
      lock_owner_q <= lock_owner_d;
    end
  end

`ifdef CORE_DMEM_ARB_RR_EN
  logic prio_q, prio_d;

  always_comb begin
    prio_d = prio_q;
    if (bus_req_i && bus_gnt_i) begin
      prio_d = ~sel_o;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prio_q <= ARB_P0;
    end else begin
      prio_q <= prio_d;
    end
  end

  assign prio = prio_q;
`else
  assign prio = ARB_P0;
`endif

endmodule

// File: rtl/core_dmem_arbiter.sv
// core_dmem_arbiter
//   Shares the core data-memory port between p0 (LSU) and p1 (debug/DMA).
//   The chosen requester is held until granted; the response, one cycle
//   after grant, is routed back to the grant owner.
//   Build option: CORE_DMEM_ARB_RR_EN (round-robin; default fixed p0 priority).
//
//   g_clk, g_resetn                    clock, async active-low reset
//   pN_req/addr/wen/strb/wdata   in    requester N command (held until pN_gnt)
//   pN_gnt                       out   request accepted this cycle
//   pN_rsp/err/rdata             out   response to requester N
//   dmem_req/addr/wen/strb/wdata out   memory command
//   dmem_gnt                     in    memory accepted command
//   dmem_err/rdata               in    memory response, cycle after dmem_gnt
module core_dmem_arbiter
  import core_dmem_arbiter_pkg::*;
#(
  parameter int AW = MEM_ADDR_R,
  parameter int DW = MEM_DATA_R,
  parameter int SW = DW / 8
) (
  input  logic          g_clk,
  input  logic          g_resetn,

  input  logic          p0_req,
  input  logic [AW-1:0] p0_addr,
  input  logic          p0_wen,
  input  logic [SW-1:0] p0_strb,
  input  logic [DW-1:0] p0_wdata,
  output logic          p0_gnt,
  output logic          p0_rsp,
  output logic          p0_err,
  output logic [DW-1:0] p0_rdata,

  input  logic          p1_req,
  input  logic [AW-1:0] p1_addr,
  input  logic          p1_wen,
  input  logic [SW-1:0] p1_strb,
  input  logic [DW-1:0] p1_wdata,
  output logic          p1_gnt,
  output logic          p1_rsp,
  output logic          p1_err,
  output logic [DW-1:0] p1_rdata,

  output logic          dmem_req,
  output logic [AW-1:0] dmem_addr,
  output logic          dmem_wen,
  output logic [SW-1:0] dmem_strb,
  output logic [DW-1:0] dmem_wdata,
  input  logic          dmem_gnt,
  input  logic          dmem_err,
  input  logic [DW-1:0] dmem_rdata
);

  logic sel;
  logic live_q;
  logic grant;
  logic rsp_pend_q, rsp_pend_d;
  logic rsp_owner_q, rsp_owner_d;

  // Holds the bus idle for the first cycle after reset release.
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      live_q <= 1'b0;
    end else begin
      live_q <= 1'b1;
    end
  end

  core_dmem_arb_sel u_sel (
    .clk_i     (g_clk),
    .rst_ni    (g_resetn),
    .req0_i    (p0_req),
    .req1_i    (p1_req),
    .bus_req_i (dmem_req),
    .bus_gnt_i (dmem_gnt),
    .sel_o     (sel)
  );

  assign dmem_req   = live_q && ((sel == ARB_P1) ? p1_req : p0_req);
  assign dmem_addr  = (sel == ARB_P1) ? p1_addr  : p0_addr;
  assign dmem_wen   = (sel == ARB_P1) ? p1_wen   : p0_wen;
  assign dmem_strb  = (sel == ARB_P1) ? p1_strb  : p0_strb;
  assign dmem_wdata = (sel == ARB_P1) ? p1_wdata : p0_wdata;

  assign grant  = dmem_req && dmem_gnt;
  assign p0_gnt = grant && (sel == ARB_P0);
  assign p1_gnt = grant && (sel == ARB_P1);

  always_comb begin
    rsp_pend_d  = grant;
    rsp_owner_d = rsp_owner_q;
    if (grant) begin
      rsp_owner_d = sel;
    end
  end

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      rsp_pend_q  <= 1'b0;
      rsp_owner_q <= ARB_P0;
    end else begin
      rsp_pend_q  <= rsp_pend_d;
      rsp_owner_q <= rsp_owner_d;
    end
  end

  assign p0_rsp   = rsp_pend_q && (rsp_owner_q == ARB_P0);
  assign p1_rsp   = rsp_pend_q && (rsp_owner_q == ARB_P1);
  assign p0_err   = p0_rsp && dmem_err;
  assign p1_err   = p1_rsp && dmem_err;
  assign p0_rdata = p0_rsp ? dmem_rdata : '0;
  assign p1_rdata = p1_rsp ? dmem_rdata : '0;

endmodule

// File: tb/tb_core_dmem_arbiter.sv
module tb_core_dmem_arbiter;

  localparam int AW = 64;
  localparam int DW = 64;
  localparam int SW = 8;

  logic          g_clk = 1'b0;
  logic          g_resetn = 1'b0;
  logic          p0_req, p0_wen, p0_gnt, p0_rsp, p0_err;
  logic [AW-1:0] p0_addr;
  logic [SW-1:0] p0_strb;
  logic [DW-1:0] p0_wdata, p0_rdata;
  logic          p1_req, p1_wen, p1_gnt, p1_rsp, p1_err;
  logic [AW-1:0] p1_addr;
  logic [SW-1:0] p1_strb;
  logic [DW-1:0] p1_wdata, p1_rdata;
  logic          dmem_req, dmem_wen, dmem_gnt, dmem_err;
  logic [AW-1:0] dmem_addr;
  logic [SW-1:0] dmem_strb;
  logic [DW-1:0] dmem_wdata, dmem_rdata;

  always #5 g_clk = ~g_clk;

  core_dmem_arbiter dut (
    .g_clk(g_clk), .g_resetn(g_resetn),
    .p0_req(p0_req), .p0_addr(p0_addr), .p0_wen(p0_wen), .p0_strb(p0_strb),
    .p0_wdata(p0_wdata), .p0_gnt(p0_gnt), .p0_rsp(p0_rsp), .p0_err(p0_err),
    .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_addr(p1_addr), .p1_wen(p1_wen), .p1_strb(p1_strb),
    .p1_wdata(p1_wdata), .p1_gnt(p1_gnt), .p1_rsp(p1_rsp), .p1_err(p1_err),
    .p1_rdata(p1_rdata),
    .dmem_req(dmem_req), .dmem_addr(dmem_addr), .dmem_wen(dmem_wen),
    .dmem_strb(dmem_strb), .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt),
    .dmem_err(dmem_err), .dmem_rdata(dmem_rdata)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // requester-side transactions
  bit            act[2];
  logic [AW-1:0] r_addr[2];
  logic [DW-1:0] r_wdata[2];
  logic          r_wen[2];
  logic [SW-1:0] r_strb[2];
  bit            allow_new = 1'b0;
  bit            keep_busy = 1'b0;
  int            gnt_force = -1;

  // reference model state (-1 = no lock)
  int m_lock = -1;
  int m_prio = 0;
  bit m_live = 1'b0;
  bit m_rsp_pend = 1'b0;
  int m_rsp_owner = 0;

  task automatic start_txn(input int p);
    act[p]     = 1'b1;
    r_addr[p]  = {$urandom, $urandom};
    r_wdata[p] = {$urandom, $urandom};
    r_wen[p]   = $urandom_range(0, 1) == 1;
    r_strb[p]  = 8'($urandom);
  endtask

  task automatic drive();
    p0_req = act[0]; p0_addr = r_addr[0]; p0_wen = r_wen[0];
    p0_strb = r_strb[0]; p0_wdata = r_wdata[0];
    p1_req = act[1]; p1_addr = r_addr[1]; p1_wen = r_wen[1];
    p1_strb = r_strb[1]; p1_wdata = r_wdata[1];
    if (gnt_force < 0) dmem_gnt = $urandom_range(0, 99) < 65;
    else               dmem_gnt = (gnt_force != 0);
    dmem_err   = $urandom_range(0, 3) == 0;
    dmem_rdata = {$urandom, $urandom};
  endtask

  // One clock cycle: entered at posedge+1 with inputs driven, leaves the same way.
  task automatic step();
    int sel;
    bit exp_req, granted, e0, e1;
    @(negedge g_clk);
    if (m_lock >= 0)               sel = m_lock;
    else if (act[0] && !act[1])    sel = 0;
    else if (act[1] && !act[0])    sel = 1;
    else                           sel = m_prio;
    exp_req = m_live && act[sel];
    granted = exp_req && dmem_gnt;

    chk("dmem_req", 64'(dmem_req), 64'(exp_req));
    chk("p0_gnt", 64'(p0_gnt), 64'(granted && sel == 0));
    chk("p1_gnt", 64'(p1_gnt), 64'(granted && sel == 1));
    if (exp_req) begin
      chk("dmem_addr", dmem_addr, r_addr[sel]);
      chk("dmem_wdata", dmem_wdata, r_wdata[sel]);
      chk("dmem_wen_strb", 64'({dmem_wen, dmem_strb}), 64'({r_wen[sel], r_strb[sel]}));
    end

    e0 = m_rsp_pend && m_rsp_owner == 0;
    e1 = m_rsp_pend && m_rsp_owner == 1;
    chk("p0_rsp", 64'(p0_rsp), 64'(e0));
    chk("p1_rsp", 64'(p1_rsp), 64'(e1));
    chk("p0_err", 64'(p0_err), 64'(e0 && dmem_err));
    chk("p1_err", 64'(p1_err), 64'(e1 && dmem_err));
    chk("p0_rdata", p0_rdata, e0 ? dmem_rdata : 64'h0);
    chk("p1_rdata", p1_rdata, e1 ? dmem_rdata : 64'h0);

    // model update from the arbitration rules
    if (granted) begin
      m_lock      = -1;
      m_rsp_pend  = 1'b1;
      m_rsp_owner = sel;
`ifdef CORE_DMEM_ARB_RR_EN
      m_prio      = 1 - sel;
`endif
    end else begin
      m_rsp_pend = 1'b0;
      if (exp_req) m_lock = sel;
    end
    m_live = 1'b1;

    @(posedge g_clk);
    #1;
    if (granted) act[sel] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (!act[i] && (keep_busy || (allow_new && $urandom_range(0, 99) < 55)))
        start_txn(i);
    end
    drive();
  endtask

  // Asynchronous reset mid-cycle; leaves at posedge+1 with reset released.
  task automatic do_reset();
    #2 g_resetn = 1'b0;
    #1;
    chk("rst_dmem_req", 64'(dmem_req), 64'h0);
    chk("rst_p0_rsp", 64'(p0_rsp), 64'h0);
    chk("rst_p1_rsp", 64'(p1_rsp), 64'h0);
    chk("rst_p0_gnt", 64'(p0_gnt), 64'h0);
    chk("rst_p1_gnt", 64'(p1_gnt), 64'h0);
    m_lock = -1; m_prio = 0; m_rsp_pend = 1'b0; m_live = 1'b0;
    repeat (2) @(posedge g_clk);
    #1 g_resetn = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      act[i] = 1'b0; r_addr[i] = '0; r_wdata[i] = '0; r_wen[i] = 1'b0; r_strb[i] = '0;
    end
    // p0 load to 0x80 waiting while reset is held
    act[0] = 1'b1; r_addr[0] = 64'h80; r_wen[0] = 1'b0; r_strb[0] = 8'h00;
    gnt_force = 1;
    drive();
    repeat (2) @(posedge g_clk);
    #1;
    chk("reset_dmem_req", 64'(dmem_req), 64'h0);
    chk("reset_rsp", 64'({p0_rsp, p1_rsp, p0_gnt, p1_gnt}), 64'h0);
    @(posedge g_clk);
    #1 g_resetn = 1'b1;
    step();              // first cycle after reset: bus held idle
    step();              // p0 granted
    step();              // p0 response

    // p1 write to 0x100, stalled three cycles; p0 arrives in cycle 2
    act[1] = 1'b1; r_addr[1] = 64'h100; r_wen[1] = 1'b1; r_strb[1] = 8'hFF;
    r_wdata[1] = 64'hDEAD_BEEF_0123_4567;
    gnt_force = 0;
    drive();
    step();
    act[0] = 1'b1; r_addr[0] = 64'h200; r_wen[0] = 1'b0; drive();
    step();
    step();
    gnt_force = 1; drive();
    step();              // p1 granted
    step();              // p0 granted, p1 response

    // both requesting every cycle, memory always ready
    keep_busy = 1'b1;
    repeat (10) step();
    keep_busy = 1'b0;

    // random traffic
    allow_new = 1'b1;
    gnt_force = -1;
    repeat (3000) step();

    // drain, then build the reset-mid-operation case
    allow_new = 1'b0;
    gnt_force = 1;
    drive();
    repeat (4) step();
    start_txn(0); drive();
    step();              // p0 granted, response pending next cycle
    start_txn(1); gnt_force = 0; drive();
    do_reset();          // p1 stalled on the bus with p0 response pending
    keep_busy = 1'b1; gnt_force = 1; drive();
    repeat (8) step();
    keep_busy = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
